// File: rtl/input_vc_unit_pkg.sv
// Shared NoC types for the router input stage: flit format, flit labels and VC states.
package input_vc_unit_pkg;
  localparam int PORT_NUM  = 5;
  localparam int PAYLOAD_W = 16;

  typedef logic [$clog2(PORT_NUM)-1:0] port_t;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

  // out_port is lookahead-routed: it names the port to take at this router.
  typedef struct packed {
    flit_label_t           flit_label;
    port_t                 out_port;
    logic [PAYLOAD_W-1:0]  payload;
  } flit_t;

  function automatic logic is_tail(flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction
endpackage

// File: rtl/input_vc_unit_circular_buffer.sv
// Registered-write circular FIFO; push+pop together is accepted even when full.
module circular_buffer
  import input_vc_unit_pkg::*;
#(
  parameter type DATA_T = flit_t,
  parameter int  DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  DATA_T                    data_i,
  output DATA_T                    data_o,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  DATA_T          r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_push, w_pop;

  assign w_pop  = pop && (r_count != '0);
  // A full buffer still takes a flit when a pop frees the slot in the same cycle.
  assign w_push = push && ((r_count != FULL_CNT) || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  assign empty  = (r_count == '0);
  assign full   = (r_count == FULL_CNT);
  assign count  = r_count;
  assign data_o = empty ? DATA_T'('0) : r_mem[r_rd_ptr];
endmodule

// File: rtl/input_vc_unit.sv
// Router input port: flit FIFO plus IDLE/VA/ACTIVE VC state machine feeding the VC and switch allocators.
module input_vc_unit
  import input_vc_unit_pkg::*;
#(
  parameter int BUFFER_DEPTH  = 8,
  parameter int ON_OFF_THRESH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  flit_t  data_i,
  input  logic   valid_flit_i,
  output logic   on_off_o,
  output logic   vc_request_o,
  output port_t  out_port_o,
  input  logic   vc_valid_i,
  output logic   switch_request_o,
  input  logic   switch_grant_i,
  output flit_t  flit_o,
  output logic   valid_flit_o,
  output logic   idle_o,
  output logic   error_o
);
  localparam int CW = $clog2(BUFFER_DEPTH) + 1;

  vc_state_t      r_state, w_state_nxt;
  port_t          r_out_port;
  logic           r_on_off, r_error;
  logic           w_full, w_empty, w_pop, w_push_ok, w_latch, w_error;
  logic [CW-1:0]  w_count, w_count_nxt;
  flit_t          w_front;

  circular_buffer #(.DATA_T(flit_t), .DEPTH(BUFFER_DEPTH)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .push   (valid_flit_i),
    .pop    (w_pop),
    .data_i (data_i),
    .data_o (w_front),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_pop            = 1'b0;
    w_latch          = 1'b0;
    w_error          = 1'b0;
    vc_request_o     = 1'b0;
    switch_request_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (w_front.flit_label == HEAD || w_front.flit_label == HEADTAIL) begin
            w_latch     = 1'b1;
            w_state_nxt = VA;
          end else begin
            // Orphan BODY/TAIL with no open packet: drop it so the port cannot wedge.
            w_pop   = 1'b1;
            w_error = 1'b1;
          end
        end
      end
      VA: begin
        vc_request_o = 1'b1;
        if (vc_valid_i) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        switch_request_o = !w_empty;
        if (switch_grant_i && !w_empty) begin
          w_pop = 1'b1;
          if (is_tail(w_front.flit_label)) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (switch_grant_i && !switch_request_o) w_error = 1'b1;
    if (valid_flit_i && w_full && !w_pop)     w_error = 1'b1;
  end

  assign w_push_ok   = valid_flit_i && (!w_full || w_pop);
  assign w_count_nxt = w_count + CW'(w_push_ok) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_out_port <= '0;
      r_on_off   <= 1'b1;
      r_error    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_error  <= w_error;
      // Stop upstream early enough to absorb flits already in flight on the link.
      r_on_off <= (BUFFER_DEPTH - int'(w_count_nxt)) > ON_OFF_THRESH;
      if (w_latch) r_out_port <= w_front.out_port;
    end
  end

  assign on_off_o     = r_on_off;
  assign out_port_o   = r_out_port;
  assign error_o      = r_error;
  assign flit_o       = w_front;
  assign valid_flit_o = switch_grant_i & switch_request_o;
  assign idle_o       = (r_state == IDLE) && w_empty;
endmodule
